imem_load_ctrl: RTL and testbench

Sequencer and arbiter for the single-port instruction memory: it shares the memory's one address/write port between the pipeline's fetch stage and a word-stream program loader. On a load request it stalls fetch, accepts `load_len` words over a valid/ready stream, and writes them to consecutive addresses from `load_base`. It then hands the port back to fetch and pulses `load_done`. It sits between the IF stage, the debug/UART loader and the instruction memory.

---
 rtl/imem_load_ctrl.sv | 116 +++++++++++
 tb/tb_imem_load_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_load_ctrl.sv
// Instruction-memory port sequencer: shares the single address/write port between
// instruction fetch and a valid/ready program-loader stream.
module imem_load_ctrl #(
  parameter int unsigned RAM_WIDTH     = 32,
  parameter int unsigned RAM_ADDR_BITS = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // fetch side
  input  logic [RAM_ADDR_BITS-1:0] cpu_pc,
  output logic [RAM_WIDTH-1:0]     cpu_instr,
  output logic                     cpu_stall,
  // loader control
  input  logic                     load_start,
  input  logic [RAM_ADDR_BITS-1:0] load_base,
  input  logic [RAM_ADDR_BITS:0]   load_len,
  input  logic [RAM_WIDTH-1:0]     ld_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  output logic                     load_busy,
  output logic                     load_done,
  // memory port
  output logic                     mem_w_en,
  output logic [RAM_ADDR_BITS-1:0] mem_pc,
  output logic [RAM_WIDTH-1:0]     mem_data_in,
  input  logic [RAM_WIDTH-1:0]     mem_instr
);

  localparam int unsigned LeftW = RAM_ADDR_BITS + 1;

  typedef enum logic [1:0] {StIdle, StLoad, StFlush} state_e;

  state_e                   state_q, state_d;
  logic [RAM_ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [LeftW-1:0]         left_q, left_d;
  logic                     w_pend_q, w_pend_d;
  logic [RAM_ADDR_BITS-1:0] w_addr_q, w_addr_d;
  logic [RAM_WIDTH-1:0]     w_data_q, w_data_d;
  logic                     load_done_q, load_done_d;

  // Next-state: FSM sequencing plus the one-deep write stage fed by accepted beats.
  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    left_d      = left_q;
    w_pend_d    = w_pend_q;
    w_addr_d    = w_addr_q;
    w_data_d    = w_data_q;
    load_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        w_pend_d = 1'b0;
        if (load_start) begin
          wr_addr_d = load_base;
          left_d    = load_len;
          // Zero-length load completes immediately without stalling fetch.
          if (load_len == '0) load_done_d = 1'b1;
          else                state_d     = StLoad;
        end
      end
      StLoad: begin
        // ld_ready is high throughout LOAD, so ld_valid alone marks a beat.
        if (ld_valid) begin
          w_pend_d  = 1'b1;
          w_data_d  = ld_data;
          w_addr_d  = wr_addr_q;
          wr_addr_d = wr_addr_q + RAM_ADDR_BITS'(1);
          left_d    = left_q - LeftW'(1);
          if (left_q == LeftW'(1)) state_d = StFlush;
        end else begin
          w_pend_d = 1'b0;
        end
      end
      StFlush: begin
        state_d     = StIdle;
        w_pend_d    = 1'b0;
        load_done_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wr_addr_q   <= '0;
      left_q      <= '0;
      w_pend_q    <= 1'b0;
      w_addr_q    <= '0;
      w_data_q    <= '0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      left_q      <= left_d;
      w_pend_q    <= w_pend_d;
      w_addr_q    <= w_addr_d;
      w_data_q    <= w_data_d;
      load_done_q <= load_done_d;
    end
  end

  // Port mux: fetch owns the memory in IDLE, the write stage owns it otherwise.
  always_comb begin
    load_busy   = (state_q != StIdle);
    ld_ready    = (state_q == StLoad);
    cpu_stall   = load_busy;
    cpu_instr   = load_busy ? '0 : mem_instr;
    mem_pc      = load_busy ? w_addr_q : cpu_pc;
    mem_data_in = w_data_q;
    mem_w_en    = load_busy & w_pend_q;
    load_done   = load_done_q;
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl: behavioural RAM, write scoreboard, scenario tasks.
module tb_imem_load_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] cpu_pc;
  logic [31:0] cpu_instr;
  logic        cpu_stall;
  logic        load_start;
  logic [10:0] load_base;
  logic [11:0] load_len;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        ld_ready;
  logic        load_busy;
  logic        load_done;
  logic        mem_w_en;
  logic [10:0] mem_pc;
  logic [31:0] mem_data_in;
  logic [31:0] mem_instr;

  int checks = 0;
  int failures = 0;

  logic [31:0] ram [2048];
  logic [31:0] exp_mem [2048];
  logic        ram_ready = 1'b0;
  logic [42:0] sb [$];

  always #5 clk = ~clk;

  imem_load_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_pc      (cpu_pc),
    .cpu_instr   (cpu_instr),
    .cpu_stall   (cpu_stall),
    .load_start  (load_start),
    .load_base   (load_base),
    .load_len    (load_len),
    .ld_data     (ld_data),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .load_busy   (load_busy),
    .load_done   (load_done),
    .mem_w_en    (mem_w_en),
    .mem_pc      (mem_pc),
    .mem_data_in (mem_data_in),
    .mem_instr   (mem_instr)
  );

  assign mem_instr = ram[mem_pc];

  // RAM writes on the falling edge; every write is matched against the scoreboard.
  always @(negedge clk) begin
    logic [42:0] e;
    if (!ram_ready) begin
      for (int k = 0; k < 2048; k++) ram[k] <= 32'hDEAD_0000 | 32'(k);
      ram_ready <= 1'b1;
    end else if (mem_w_en === 1'b1) begin
      ram[mem_pc] <= mem_data_in;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", mem_pc,
                 mem_data_in);
      end else begin
        e = sb.pop_front();
        if ({mem_pc, mem_data_in} !== e) begin
          failures++;
          $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h", mem_pc,
                   mem_data_in, e[42:32], e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_back(input logic [10:0] addr);
    cpu_pc = addr;
    tick();
    checks++;
    if (cpu_instr !== exp_mem[addr]) begin
      failures++;
      $display("FAIL readback[%h]: got %h, required %h", addr, cpu_instr, exp_mem[addr]);
    end
  endtask

  // Full load: start, feed n beats (optionally alternating bubbles, optionally a stray
  // load_start mid-load), then check FLUSH, load_done timing and scoreboard drain.
  task automatic run_load(input logic [10:0] base, input int n, input bit bubbles,
                          input bit poke, input logic [31:0] d0);
    int c, i, exp_done;
    bit prev_acc;
    logic [10:0] a;
    tick();
    load_start = 1'b1; load_base = base; load_len = 12'(n);
    tick();
    load_start = 1'b0;
    c = 1;
    checks++;
    if (ld_ready !== 1'b1 || cpu_stall !== 1'b1) begin
      failures++;
      $display("FAIL start: got ready=%b stall=%b, required 1 1", ld_ready, cpu_stall);
    end
    i = 0;
    prev_acc = 1'b0;
    while (i < n && c < 2 * n + 10) begin
      checks++;
      if (mem_w_en !== prev_acc || cpu_instr !== 32'h0 || load_done !== 1'b0) begin
        failures++;
        $display("FAIL in_load c=%0d: got w_en=%b instr=%h done=%b, required %b 0 0", c,
                 mem_w_en, cpu_instr, load_done, prev_acc);
      end
      load_start = poke && (c == 2);
      load_base  = 11'h300;
      load_len   = 12'd1;
      if (bubbles && (c % 2 == 0)) begin
        ld_valid = 1'b0;
      end else begin
        ld_valid = 1'b1;
        ld_data  = d0 + 32'(i);
      end
      prev_acc = ld_valid && ld_ready;
      if (prev_acc) begin
        a = base + 11'(i);
        sb.push_back({a, d0 + 32'(i)});
        exp_mem[a] = d0 + 32'(i);
        i++;
      end
      tick();
      c++;
    end
    ld_valid   = 1'b0;
    load_start = 1'b0;
    checks++;
    if (i != n) begin
      failures++;
      $display("FAIL beat_timeout: got %0d beats, required %0d", i, n);
    end
    checks++;
    if (load_busy !== 1'b1 || ld_ready !== 1'b0 || mem_w_en !== 1'b1 || load_done !== 1'b0) begin
      failures++;
      $display("FAIL flush: got busy=%b ready=%b w_en=%b done=%b, required 1 0 1 0",
               load_busy, ld_ready, mem_w_en, load_done);
    end
    tick();
    c++;
    exp_done = bubbles ? 2 * n + 1 : n + 2;
    checks++;
    if (load_done !== 1'b1 || c != exp_done || cpu_stall !== 1'b0 || load_busy !== 1'b0 ||
        mem_pc !== cpu_pc) begin
      failures++;
      $display("FAIL done: got done=%b cycle=%0d stall=%b busy=%b pc=%h, required 1 %0d 0 0 %h",
               load_done, c, cpu_stall, load_busy, mem_pc, exp_done, cpu_pc);
    end
    tick();
    checks++;
    if (load_done !== 1'b0 || sb.size() != 0) begin
      failures++;
      $display("FAIL done_pulse: got done=%b pending=%0d, required 0 0", load_done, sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cpu_pc = 11'h010; load_start = 1'b0; load_base = '0; load_len = '0;
    ld_data = '0; ld_valid = 1'b0;
    for (int k = 0; k < 2048; k++) exp_mem[k] = 32'hDEAD_0000 | 32'(k);
    tick();
    tick();
    checks++;
    if (mem_w_en !== 1'b0 || ld_ready !== 1'b0 || cpu_stall !== 1'b0 || load_busy !== 1'b0 ||
        load_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got w_en=%b ready=%b stall=%b busy=%b done=%b, required 0",
               mem_w_en, ld_ready, cpu_stall, load_busy, load_done);
    end
    checks++;
    if (mem_pc !== 11'h010 || cpu_instr !== exp_mem[11'h010]) begin
      failures++;
      $display("FAIL reset_fetch: got pc=%h instr=%h, required 010 %h", mem_pc, cpu_instr,
               exp_mem[11'h010]);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_load(11'h100, 4, 1'b0, 1'b0, 32'hA0);
    for (int k = 0; k < 4; k++) read_back(11'h100 + 11'(k));
  endtask

  task automatic test_bubbles();
    run_load(11'h180, 4, 1'b1, 1'b0, 32'hB0);
    for (int k = 0; k < 4; k++) read_back(11'h180 + 11'(k));
  endtask

  task automatic test_wrap();
    run_load(11'h7FE, 3, 1'b0, 1'b0, 32'hC0);
    read_back(11'h7FE);
    read_back(11'h7FF);
    read_back(11'h000);
  endtask

  task automatic test_len_zero();
    tick();
    load_start = 1'b1; load_base = 11'h050; load_len = 12'd0; ld_valid = 1'b1; ld_data = 32'h77;
    tick();
    load_start = 1'b0;
    checks++;
    if (load_done !== 1'b1 || cpu_stall !== 1'b0 || ld_ready !== 1'b0 || load_busy !== 1'b0) begin
      failures++;
      $display("FAIL len0_c1: got done=%b stall=%b ready=%b busy=%b, required 1 0 0 0",
               load_done, cpu_stall, ld_ready, load_busy);
    end
    tick();
    ld_valid = 1'b0;
    checks++;
    if (load_done !== 1'b0 || cpu_stall !== 1'b0) begin
      failures++;
      $display("FAIL len0_c2: got done=%b stall=%b, required 0 0", load_done, cpu_stall);
    end
    read_back(11'h050);
  endtask

  task automatic test_interference();
    run_load(11'h200, 4, 1'b0, 1'b1, 32'hD0);
    for (int k = 0; k < 4; k++) read_back(11'h200 + 11'(k));
    read_back(11'h300);
  endtask

  task automatic test_reset_mid_load();
    tick();
    load_start = 1'b1; load_base = 11'h400; load_len = 12'd4;
    tick();
    load_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ld_valid = 1'b1; ld_data = 32'hE0 + 32'(k);
      sb.push_back({11'h400 + 11'(k), 32'hE0 + 32'(k)});
      exp_mem[11'h400 + 11'(k)] = 32'hE0 + 32'(k);
      tick();
    end
    ld_valid = 1'b0;
    rst_n = 1'b0;
    checks++;
    if (mem_w_en !== 1'b1) begin
      failures++;
      $display("FAIL rst_last_write: got w_en=%b, required 1", mem_w_en);
    end
    tick();
    rst_n = 1'b1;
    checks++;
    if (cpu_stall !== 1'b0 || ld_ready !== 1'b0 || load_busy !== 1'b0 || mem_w_en !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid: got stall=%b ready=%b busy=%b w_en=%b, required 0", cpu_stall,
               ld_ready, load_busy, mem_w_en);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (load_done !== 1'b0) begin
        failures++;
        $display("FAIL rst_no_done: got done=%b, required 0", load_done);
      end
      tick();
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL rst_pending: got %0d unwritten, required 0", sb.size());
    end
    for (int k = 0; k < 4; k++) read_back(11'h400 + 11'(k));
  endtask

  task automatic test_full_size();
    run_load(11'h000, 2048, 1'b0, 1'b0, 32'h5000_0000);
    read_back(11'h000);
    read_back(11'h400);
    read_back(11'h7FF);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_wrap();
    test_len_zero();
    test_interference();
    test_reset_mid_load();
    test_full_size();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
